// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: write-only port A, read-only port B, one common clock.
// Read latency 1 cycle; no backpressure, both ports accept every enabled cycle.
module simple_dual_port_ram #(
    parameter int    DATA_DEPTH       = 128,
    parameter int    DATA_WIDTH       = 32,
    parameter int    BYTE_WRITE_WIDTH = 32,
    parameter string CLOCKING_MODE    = "common_clock",
    parameter string WRITE_MODE       = "write_first",
    parameter string MEMORY_PRIMITIVE = "auto",
    localparam int   ADDR_WIDTH       = ($clog2(DATA_DEPTH) < 1) ? 1 : $clog2(DATA_DEPTH),
    localparam int   NUM_LANES        = DATA_WIDTH / BYTE_WRITE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstb_n,
    input  logic                  en_a_i,
    input  logic [NUM_LANES-1:0]  we_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic                  en_b_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    output logic [DATA_WIDTH-1:0] data_b_o
);

    localparam bit MODE_WF = (WRITE_MODE == "write_first");
    localparam bit MODE_RF = (WRITE_MODE == "read_first");
    localparam bit MODE_NC = (WRITE_MODE == "no_change");
    localparam bit PRIM_OK = (MEMORY_PRIMITIVE == "auto")        || (MEMORY_PRIMITIVE == "block") ||
                             (MEMORY_PRIMITIVE == "distributed") || (MEMORY_PRIMITIVE == "register");
    localparam logic [ADDR_WIDTH:0] DEPTH_L = DATA_DEPTH[ADDR_WIDTH:0];

    if (CLOCKING_MODE != "common_clock") begin : g_bad_clocking
        $error("simple_dual_port_ram: only common_clock is supported");
    end
    if (!(MODE_WF || MODE_RF || MODE_NC)) begin : g_bad_write_mode
        $error("simple_dual_port_ram: unknown WRITE_MODE");
    end
    if (!PRIM_OK) begin : g_bad_primitive
        $error("simple_dual_port_ram: unknown MEMORY_PRIMITIVE");
    end
    if (DATA_DEPTH < 2 || BYTE_WRITE_WIDTH < 1 || (DATA_WIDTH % BYTE_WRITE_WIDTH) != 0) begin : g_bad_geometry
        $error("simple_dual_port_ram: illegal depth or lane geometry");
    end

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
    logic                  in_range_a;
    logic                  in_range_b;
    logic                  collide;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] wf_word;
    logic [DATA_WIDTH-1:0] data_b_q;

    // Non-power-of-two depths leave a hole in the address space: drop writes, read zero.
    assign in_range_a = ({1'b0, addr_a_i} < DEPTH_L);
    assign in_range_b = ({1'b0, addr_b_i} < DEPTH_L);
    assign collide    = en_a_i && en_b_i && in_range_a && (addr_a_i == addr_b_i);

    always_ff @(posedge clk) begin
        if (en_a_i && in_range_a) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we_a_i[i]) begin
                    mem[addr_a_i][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
                        data_a_i[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (in_range_b) begin
            rd_word = mem[addr_b_i];
        end
    end

    // Bypass only the lanes being written so the read sees the post-write word.
    always_comb begin
        wf_word = rd_word;
        if (collide) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (we_a_i[i]) begin
                    wf_word[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
                        data_a_i[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstb_n) begin
            data_b_q <= '0;
        end else if (en_b_i) begin
            if (MODE_RF) begin
                data_b_q <= rd_word;
            end else if (MODE_NC) begin
                if (!collide) begin
                    data_b_q <= rd_word;
                end
            end else begin
                data_b_q <= wf_word;
            end
        end
    end

    assign data_b_o = data_b_q;

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench: three collision-mode variants share stimulus; a depth-6 instance checks wrap/holes.
module tb_simple_dual_port_ram;

    logic        clk = 1'b0;
    logic        rstb_n;
    logic        en_a, en_b;
    logic [3:0]  we_a;
    logic [6:0]  addr_a, addr_b;
    logic [31:0] data_a;
    logic [31:0] q_wf, q_rf, q_nc;

    logic        en_a6, en_b6;
    logic [2:0]  addr_a6, addr_b6;
    logic [31:0] data_a6;
    logic [31:0] q_d6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    simple_dual_port_ram #(.DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .WRITE_MODE("write_first")) u_wf (
        .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a),
        .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b), .data_b_o(q_wf));

    simple_dual_port_ram #(.DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .WRITE_MODE("read_first")) u_rf (
        .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a),
        .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b), .data_b_o(q_rf));

    simple_dual_port_ram #(.DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .WRITE_MODE("no_change")) u_nc (
        .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a), .we_a_i(we_a), .addr_a_i(addr_a),
        .data_a_i(data_a), .en_b_i(en_b), .addr_b_i(addr_b), .data_b_o(q_nc));

    simple_dual_port_ram #(.DATA_DEPTH(6), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(32)) u_d6 (
        .clk(clk), .rstb_n(rstb_n), .en_a_i(en_a6), .we_a_i(1'b1), .addr_a_i(addr_a6),
        .data_a_i(data_a6), .en_b_i(en_b6), .addr_b_i(addr_b6), .data_b_o(q_d6));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] we);
        en_a = 1'b1; addr_a = a; data_a = d; we_a = we;
    endtask

    initial begin
        en_a = 0; en_b = 0; we_a = 4'hF; addr_a = 0; addr_b = 0; data_a = 0;
        en_a6 = 0; en_b6 = 0; addr_a6 = 0; addr_b6 = 0; data_a6 = 0;

        // Reset with reads enabled; a write lands in memory during reset.
        rstb_n = 0; en_b = 1; addr_b = 7'd5;
        wr(7'd5, 32'h5555_5555, 4'hF);
        en_b6 = 1;
        tick();
        en_a = 0;
        tick();
        chk("rst_wf", q_wf, 32'h0);
        chk("rst_rf", q_rf, 32'h0);
        chk("rst_nc", q_nc, 32'h0);
        chk("rst_d6", q_d6, 32'h0);
        rstb_n = 1;
        tick();
        chk("rst_rel_wf", q_wf, 32'h5555_5555);
        chk("rst_rel_nc", q_nc, 32'h5555_5555);

        // Basic write then read: data appears only after the read-address edge.
        wr(7'd3, 32'hDEAD_BEEF, 4'hF);
        tick();
        chk("basic_not_before", q_wf, 32'h5555_5555);
        en_a = 0; addr_b = 7'd3;
        tick();
        chk("basic_wf", q_wf, 32'hDEAD_BEEF);
        chk("basic_rf", q_rf, 32'hDEAD_BEEF);

        // Same-address collision across the three modes.
        wr(7'd7, 32'h1111_1111, 4'hF);
        tick();
        wr(7'd7, 32'h2222_2222, 4'hF); addr_b = 7'd7;
        tick();
        chk("coll_wf", q_wf, 32'h2222_2222);
        chk("coll_rf", q_rf, 32'h1111_1111);
        chk("coll_nc", q_nc, 32'hDEAD_BEEF);
        en_a = 0;
        tick();
        chk("post_coll_nc", q_nc, 32'h2222_2222);
        chk("post_coll_rf", q_rf, 32'h2222_2222);

        // Partial-lane write colliding with a read of the same word.
        wr(7'd0, 32'hAABB_CCDD, 4'hF);
        tick();
        wr(7'd0, 32'h1122_3344, 4'b0101); addr_b = 7'd0;
        tick();
        chk("lane_coll_wf", q_wf, 32'hAA22_CC44);
        chk("lane_coll_rf", q_rf, 32'hAABB_CCDD);
        en_a = 0;
        tick();
        chk("lane_rd_wf", q_wf, 32'hAA22_CC44);
        chk("lane_rd_nc", q_nc, 32'hAA22_CC44);

        // Different-address write and read in one cycle stay independent.
        wr(7'd1, 32'h0101_0101, 4'hF); addr_b = 7'd3;
        tick();
        chk("indep_wf", q_wf, 32'hDEAD_BEEF);
        chk("indep_nc", q_nc, 32'hDEAD_BEEF);

        // Port A disabled: the write must not land.
        en_a = 0; addr_a = 7'd1; data_a = 32'hFFFF_FFFF; we_a = 4'hF; addr_b = 7'd1;
        tick();
        tick();
        chk("ena_off", q_wf, 32'h0101_0101);

        // Port B disabled: output holds while the address moves.
        en_b = 0; addr_b = 7'd3;
        tick();
        chk("enb_hold0", q_wf, 32'h0101_0101);
        addr_b = 7'd7;
        tick();
        chk("enb_hold1", q_rf, 32'h0101_0101);

        // Reset beats an idle port B, then beats an enabled one.
        rstb_n = 0;
        tick();
        chk("rst_over_hold", q_wf, 32'h0);
        en_b = 1;
        tick();
        chk("rst_prio", q_rf, 32'h0);
        rstb_n = 1;
        tick();
        chk("rst_prio_rel", q_wf, 32'h2222_2222);

        // Depth 6: fill every word, poke the two holes, read back.
        for (int i = 0; i < 8; i++) begin
            en_a6 = 1; addr_a6 = 3'(i); data_a6 = (i < 6) ? (32'hC0DE_0000 + 32'(i)) : 32'hBAD0_0BAD;
            tick();
        end
        en_a6 = 0;
        for (int i = 0; i < 8; i++) begin
            addr_b6 = 3'(i);
            tick();
            chk($sformatf("d6_rd%0d", i), q_d6, (i < 6) ? (32'hC0DE_0000 + 32'(i)) : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
